// File: rtl/pwm_duty_monitor.sv
// Measures period, signed net duty and dead time of one PWM1/PWM2 motor pair,
// flagging shoot-through overlap and outputs that stop toggling.
module pwm_duty_monitor #(
  parameter int CNT_W   = 13,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             PWM1,
  input  logic             PWM2,
  input  logic             clr_err,
  output logic [CNT_W:0]   duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] dead,
  output logic             meas_vld,
  output logic             overlap_err,
  output logic             stuck
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   DUTY_POS = {1'b0, CNT_MAX};
  // -(2^CNT_W-1) in CNT_W+1 bits is 1 followed by zeros and a trailing 1
  localparam logic [CNT_W:0]   DUTY_NEG = {1'b1, {(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;
  state_t state, state_nxt;

  logic             p1_q, p2_q, p1_qq;
  logic             rise, latch, reload, count;
  logic [CNT_W-1:0] per, hi1, hi2, dc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, inc};
  endfunction

  assign rise   = p1_q & ~p1_qq;
  assign latch  = en & rise & (state == MEAS);
  assign reload = en & rise;
  assign count  = (state == MEAS) & (state_nxt == MEAS) & ~rise;
  assign stuck  = (state == STUCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q  <= 1'b0;
      p2_q  <= 1'b0;
      p1_qq <= 1'b0;
    end else begin
      p1_q  <= PWM1;
      p2_q  <= PWM2;
      p1_qq <= p1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // rise has priority over the timeout so a period of exactly TIMEOUT still latches
  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (rise) state_nxt = MEAS;
        MEAS:    if (!rise && per >= TO_CNT) state_nxt = STUCK;
        STUCK:   if (rise) state_nxt = MEAS;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per <= '0;
      hi1 <= '0;
      hi2 <= '0;
      dc  <= '0;
    end else if (reload) begin
      per <= CNT_ONE;
      hi1 <= CNT_ONE;
      hi2 <= {{(CNT_W-1){1'b0}}, p2_q};
      dc  <= '0;
    end else if (count) begin
      per <= sat_inc(per, 1'b1);
      hi1 <= sat_inc(hi1, p1_q);
      hi2 <= sat_inc(hi2, p2_q);
      dc  <= sat_inc(dc, ~p1_q & ~p2_q);
    end else begin
      per <= '0;
      hi1 <= '0;
      hi2 <= '0;
      dc  <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty     <= '0;
      period   <= '0;
      dead     <= '0;
      meas_vld <= 1'b0;
    end else begin
      meas_vld <= latch;
      if (latch) begin
        period <= per;
        dead   <= dc;
        duty   <= {1'b0, hi1} - {1'b0, hi2};
      end else if (state_nxt == STUCK) begin
        duty <= p1_q ? DUTY_POS : (p2_q ? DUTY_NEG : '0);
      end
    end
  end

  // a fresh overlap beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    overlap_err <= 1'b0;
    else if (en & p1_q & p2_q)  overlap_err <= 1'b1;
    else if (clr_err)           overlap_err <= 1'b0;
  end

endmodule

// File: tb/tb_pwm_duty_monitor.sv
// Directed bench for pwm_duty_monitor: expected measurements go into a queue
// as each period starts; a monitor pops and compares on every meas_vld.
module tb_pwm_duty_monitor;
  localparam int CNT_W = 13;

  typedef struct {
    logic [CNT_W:0]   duty;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] dead;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, en, PWM1, PWM2, clr_err;
  logic [CNT_W:0]   duty;
  logic [CNT_W-1:0] period, dead;
  logic             meas_vld, overlap_err, stuck;

  exp_t sb[$];
  exp_t pending;
  bit   armed = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwm_duty_monitor #(.CNT_W(CNT_W), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .en(en), .PWM1(PWM1), .PWM2(PWM2), .clr_err(clr_err),
    .duty(duty), .period(period), .dead(dead), .meas_vld(meas_vld),
    .overlap_err(overlap_err), .stuck(stuck)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pins change on the falling edge; one edge samples, the next latches
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (meas_vld) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas_vld: got meas_vld=1 at cycle %0d expected no measurement", cyc);
      end else begin
        e = sb.pop_front();
        chk("duty",    32'(duty),   32'(e.duty));
        chk("period",  32'(period), 32'(e.period));
        chk("dead",    32'(dead),   32'(e.dead));
        chk("latency", 32'(cyc),    32'(e.cyc));
      end
    end
  end

  task automatic drive(input logic p1, input logic p2, input int n);
    PWM1 = p1;
    PWM2 = p2;
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int h1, input int g1, input int h2, input int g2);
    drive(1'b1, 1'b0, h1);
    drive(1'b0, 1'b0, g1);
    drive(1'b0, 1'b1, h2);
    drive(1'b0, 1'b0, g2);
  endtask

  // called just before a PWM1 rise: the rise completes the previous window
  task automatic start_period(input logic [CNT_W:0] d, input int p, input int dd);
    if (armed) begin
      pending.cyc = cyc + 2;
      sb.push_back(pending);
    end
    pending.duty   = d;
    pending.period = CNT_W'(p);
    pending.dead   = CNT_W'(dd);
    armed = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; PWM1 = 1'b0; PWM2 = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty",    32'(duty),        32'd0);
    chk("rst_period",  32'(period),      32'd0);
    chk("rst_dead",    32'(dead),        32'd0);
    chk("rst_meas",    32'(meas_vld),    32'd0);
    chk("rst_overlap", 32'(overlap_err), 32'd0);
    chk("rst_stuck",   32'(stuck),       32'd0);
    rst = 1'b0;
    en  = 1'b1;
    drive(1'b0, 1'b0, 5);

    // test 1: forward drive, +452
    for (int i = 0; i < 4; i++) begin
      start_period(14'd452, 2048, 100);
      wave(1200, 50, 748, 50);
    end
    chk("t1_overlap", 32'(overlap_err), 32'd0);

    // test 2: reverse drive, -452
    for (int i = 0; i < 3; i++) begin
      start_period(14'h3E3C, 2048, 100);
      wave(748, 50, 1200, 50);
    end
    chk("t2_overlap", 32'(overlap_err), 32'd0);

    // test 3: overlap, sticky, clear, clear-with-overlap
    start_period(14'd451, 2048, 100);
    drive(1'b1, 1'b0, 600);
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 599);
    drive(1'b0, 1'b0, 50);
    drive(1'b0, 1'b1, 748);
    drive(1'b0, 1'b0, 50);
    chk("t3_overlap_sticky", 32'(overlap_err), 32'd1);
    start_period(14'd451, 2048, 100);
    drive(1'b1, 1'b0, 100);
    clr_err = 1'b1;
    drive(1'b1, 1'b0, 1);
    clr_err = 1'b0;
    chk("t3_overlap_cleared", 32'(overlap_err), 32'd0);
    drive(1'b1, 1'b1, 1);
    clr_err = 1'b1;
    drive(1'b1, 1'b0, 1);
    clr_err = 1'b0;
    chk("t3_set_beats_clear", 32'(overlap_err), 32'd1);
    drive(1'b1, 1'b0, 1097);
    drive(1'b0, 1'b0, 50);
    drive(1'b0, 1'b1, 748);
    drive(1'b0, 1'b0, 50);

    // test 4: PWM2 stuck high
    start_period(14'd0, 0, 0);
    armed = 1'b0;
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 4096);
    chk("t4_not_yet_stuck", 32'(stuck), 32'd0);
    drive(1'b0, 1'b1, 1);
    chk("t4_stuck", 32'(stuck), 32'd1);
    chk("t4_stuck_duty", 32'(duty), 32'h2001);
    chk("t4_period_held", 32'(period), 32'd2048);
    chk("t4_dead_held", 32'(dead), 32'd100);
    clr_err = 1'b1;
    drive(1'b0, 1'b1, 1);
    clr_err = 1'b0;
    drive(1'b0, 1'b1, 902);
    chk("t4_overlap_cleared", 32'(overlap_err), 32'd0);
    drive(1'b0, 1'b0, 50);
    start_period(14'd452, 2048, 100);
    drive(1'b1, 1'b0, 1);
    chk("t4_stuck_before_rise", 32'(stuck), 32'd1);
    drive(1'b1, 1'b0, 1);
    chk("t4_stuck_released", 32'(stuck), 32'd0);
    drive(1'b1, 1'b0, 1198);
    drive(1'b0, 1'b0, 50);
    drive(1'b0, 1'b1, 748);
    drive(1'b0, 1'b0, 50);

    // test 5: enable dropped mid-period
    start_period(14'd452, 2048, 100);
    drive(1'b1, 1'b0, 600);
    en = 1'b0;
    armed = 1'b0;
    drive(1'b1, 1'b0, 600);
    drive(1'b0, 1'b0, 50);
    drive(1'b0, 1'b1, 748);
    drive(1'b0, 1'b0, 50);
    wave(1200, 50, 748, 50);
    chk("t5_duty_held",   32'(duty),     32'd452);
    chk("t5_period_held", 32'(period),   32'd2048);
    chk("t5_dead_held",   32'(dead),     32'd100);
    chk("t5_meas_low",    32'(meas_vld), 32'd0);
    drive(1'b1, 1'b0, 1200);
    drive(1'b0, 1'b0, 50);
    drive(1'b0, 1'b1, 300);
    en = 1'b1;
    drive(1'b0, 1'b1, 448);
    drive(1'b0, 1'b0, 50);
    for (int i = 0; i < 2; i++) begin
      start_period(14'd452, 2048, 100);
      wave(1200, 50, 748, 50);
    end

    // test 6: asynchronous reset mid-period
    start_period(14'd452, 2048, 100);
    drive(1'b1, 1'b0, 600);
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 599);
    drive(1'b0, 1'b0, 50);
    drive(1'b0, 1'b1, 300);
    chk("t6_overlap_pre", 32'(overlap_err), 32'd1);
    chk("t6_duty_pre",    32'(duty),        32'd452);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_duty",    32'(duty),        32'd0);
    chk("t6_rst_period",  32'(period),      32'd0);
    chk("t6_rst_dead",    32'(dead),        32'd0);
    chk("t6_rst_overlap", 32'(overlap_err), 32'd0);
    chk("t6_rst_stuck",   32'(stuck),       32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    armed = 1'b0;
    drive(1'b0, 1'b1, 446);
    drive(1'b0, 1'b0, 50);
    for (int i = 0; i < 3; i++) begin
      start_period(14'd452, 2048, 100);
      wave(1200, 50, 748, 50);
    end
    start_period(14'd0, 0, 0);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
